// File: rtl/game_move_sequencer.sv
// game_move_sequencer: conditions four direction buttons and sequences each accepted
// move through the 2048 board datapath (move, spawn, check), committing only at vblank.
module game_move_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             up_button,
    input  logic             down_button,
    input  logic             left_button,
    input  logic             right_button,
    input  logic             vblank,
    output logic             mv_valid,
    output logic [1:0]       mv_dir,
    input  logic             mv_done,
    input  logic             mv_changed,
    output logic             spawn_req,
    input  logic             spawn_ack,
    output logic             chk_req,
    input  logic             chk_done,
    input  logic             chk_dead,
    output logic             busy,
    output logic             death,
    output logic [CNT_W-1:0] move_count
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_MOVE  = 3'd2;
    localparam logic [2:0] S_SPAWN = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DEAD  = 3'd5;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       w_raw;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_db;
    logic [CNT_W-1:0] r_cnt [4];
    logic             r_rdy;
    logic             r_armed;
    logic [2:0]       r_state;
    logic [1:0]       r_dir;
    logic [CNT_W-1:0] r_moves;
    logic [1:0]       w_pick;
    logic             w_accept;
    logic             w_release;

    assign w_raw     = {right_button, left_button, down_button, up_button};
    assign w_pick    = r_db[0] ? 2'd0 : r_db[1] ? 2'd1 : r_db[2] ? 2'd2 : 2'd3;
    assign w_accept  = (r_state == S_IDLE) && r_armed && (|r_db);
    // Arming waits until the synchroniser carries real pin values, so a button held through reset stays disarmed.
    assign w_release = r_rdy && (r_db == 4'd0) && (r_sync1 == 4'd0) && (r_sync2 == 4'd0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_rdy   <= 1'b0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_rdy   <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) r_cnt[i] <= '0;
                else if (r_cnt[i] == DB_LAST) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_dir   <= 2'd0;
            r_armed <= 1'b0;
            r_moves <= '0;
        end else begin
            if (w_accept) r_armed <= 1'b0;
            else if (w_release) r_armed <= 1'b1;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_dir   <= w_pick;
                    r_state <= S_WAIT;
                end
                S_WAIT:  if (vblank) r_state <= S_MOVE;
                S_MOVE:  if (mv_done) r_state <= mv_changed ? S_SPAWN : S_IDLE;
                S_SPAWN: if (spawn_ack) begin
                    r_moves <= (&r_moves) ? r_moves : r_moves + 1'b1;
                    r_state <= S_CHECK;
                end
                S_CHECK: if (chk_done) r_state <= chk_dead ? S_DEAD : S_IDLE;
                S_DEAD:  r_state <= S_DEAD;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mv_valid   = r_state == S_MOVE;
    assign mv_dir     = r_dir;
    assign spawn_req  = r_state == S_SPAWN;
    assign chk_req    = r_state == S_CHECK;
    assign death      = r_state == S_DEAD;
    assign busy       = (r_state != S_IDLE) && (r_state != S_DEAD);
    assign move_count = r_moves;
endmodule

// File: tb/tb_game_move_sequencer.sv
// tb_game_move_sequencer: randomized button/datapath stimulus with a queue scoreboard
// and a press-level reference model for direction, move count and death.
module tb_game_move_sequencer;
    localparam int DB = 12;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 0, clr = 1;
    logic up_button = 0, down_button = 0, left_button = 0, right_button = 0;
    logic vblank = 0, mv_done = 0, mv_changed = 0, spawn_ack = 0, chk_done = 0, chk_dead = 0;
    logic mv_valid, spawn_req, chk_req, busy, death;
    logic [1:0] mv_dir;
    logic [CW-1:0] move_count;

    int n_checks = 0, n_fail = 0;
    logic [1:0] q_dir [$];
    logic [CW-1:0] q_cnt [$];
    int m_count = 0;
    bit m_armed = 0, m_dead = 0, exp_death = 0;
    int chg_mode = 0;
    bit dead_next = 0, hold_ack = 0;
    logic pm = 0, ps = 0, pc = 0, pd = 0;
    logic [1:0] dir_hold = 0;

    game_move_sequencer #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr),
        .up_button(up_button), .down_button(down_button),
        .left_button(left_button), .right_button(right_button),
        .vblank(vblank), .mv_valid(mv_valid), .mv_dir(mv_dir),
        .mv_done(mv_done), .mv_changed(mv_changed),
        .spawn_req(spawn_req), .spawn_ack(spawn_ack),
        .chk_req(chk_req), .chk_done(chk_done), .chk_dead(chk_dead),
        .busy(busy), .death(death), .move_count(move_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic [3:0] p);
        {right_button, left_button, down_button, up_button} = p;
    endtask

    function automatic logic [1:0] prio(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (p[i]) return 2'(i);
        return 2'd3;
    endfunction

    task automatic flush_model();
        q_dir.delete();
        q_cnt.delete();
        m_count = 0;
        m_armed = 0;
        m_dead = 0;
        exp_death = 0;
    endtask

    task automatic wait_busy(input logic lvl, input int limit, input string name);
        int t = 0;
        while (busy !== lvl && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(name, busy, lvl);
    endtask

    task automatic run_move(input logic [3:0] p, input int hold);
        bit exp;
        exp = m_armed && !m_dead && (p != 4'd0);
        set_btn(p);
        if (exp) begin
            q_dir.push_back(prio(p));
            m_armed = 0;
            wait_busy(1'b1, DB + 20, "press_accepted");
            wait_busy(1'b0, 3000, "move_finished");
        end
        cyc(hold);
        set_btn(4'd0);
        cyc(DB + 3 + $urandom_range(0, 5));
        m_armed = 1;
    endtask

    task automatic glitch(input logic [3:0] p, input int len);
        set_btn(p);
        cyc(len);
        set_btn(4'd0);
        cyc(DB + 5);
        check("glitch_no_move", busy, 1'b0);
    endtask

    // vblank: one-cycle pulses at random spacing
    initial forever begin
        repeat ($urandom_range(4, 25)) @(negedge clk);
        vblank = 1;
        @(negedge clk);
        vblank = 0;
    end

    // board datapath responder; also fires stray done/ack pulses while nothing is requested
    initial forever begin
        @(negedge clk);
        mv_done = 0; spawn_ack = 0; chk_done = 0;
        mv_changed = 1'($urandom_range(0, 1));
        chk_dead = 1'($urandom_range(0, 1));
        if (clr) begin
            if (mv_valid && $urandom_range(0, 2) == 0) begin
                mv_done = 1;
                mv_changed = chg_mode == 1 ? 1'b1 : chg_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
                if (mv_changed) begin
                    m_count = m_count == CMAX ? m_count : m_count + 1;
                    q_cnt.push_back(CW'(m_count));
                end
            end else if (!mv_valid && $urandom_range(0, 15) == 0) mv_done = 1;
            if (spawn_req && !hold_ack && $urandom_range(0, 2) == 0) spawn_ack = 1;
            else if (!spawn_req && $urandom_range(0, 15) == 0) spawn_ack = 1;
            if (chk_req && $urandom_range(0, 2) == 0) begin
                chk_done = 1;
                chk_dead = dead_next;
                if (dead_next) exp_death = 1;
            end else if (!chk_req && $urandom_range(0, 15) == 0) chk_done = 1;
        end
    end

    // monitor: pops expectations whenever the DUT presents a command
    initial forever begin
        @(posedge clk);
        #1;
        check("req_onehot", 32'($countones({mv_valid, spawn_req, chk_req}) <= 1), 1);
        if (mv_valid && !pm) begin
            check("mv_after_vblank", vblank, 1'b1);
            check("move_expected", 32'(q_dir.size() > 0), 1);
            if (q_dir.size() > 0) check("mv_dir", mv_dir, q_dir.pop_front());
            dir_hold = mv_dir;
        end
        if (mv_valid && pm) check("mv_dir_stable", mv_dir, dir_hold);
        if (spawn_req && !ps) check("spawn_expected", 32'(q_cnt.size() > 0), 1);
        if (chk_req && !pc) begin
            check("check_expected", 32'(q_cnt.size() > 0), 1);
            if (q_cnt.size() > 0) check("move_count", move_count, q_cnt.pop_front());
        end
        if (death && !pd) begin
            check("death_expected", exp_death, 1'b1);
            check("death_after_chk", chk_done & chk_dead, 1'b1);
        end
        pm = mv_valid; ps = spawn_req; pc = chk_req; pd = death;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset with up held: that press must never become a move
        set_btn(4'b0001);
        #1 clr = 0;
        cyc(3);
        check("rst_mv_valid", mv_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_death", death, 1'b0);
        check("rst_count", move_count, 0);
        check("rst_reqs", {spawn_req, chk_req}, 0);
        clr = 1;
        cyc(3 * DB);
        check("held_through_reset", busy, 1'b0);
        set_btn(4'd0);
        cyc(DB + 3);
        m_armed = 1;

        // down press: exact debounce latency, then the move itself
        set_btn(4'b0010);
        q_dir.push_back(2'd1);
        m_armed = 0;
        cyc(DB + 2);
        check("db_latency_before", busy, 1'b0);
        cyc(1);
        check("db_latency_after", busy, 1'b1);
        wait_busy(1'b0, 3000, "move_finished");
        set_btn(4'd0);
        cyc(DB + 3);
        m_armed = 1;

        chg_mode = 1;
        run_move(4'b0001, 5);
        check("count_after_up", move_count, m_count);
        check("no_death", death, 1'b0);
        run_move(4'b1100, 3 * DB);
        for (int i = 0; i < 4; i++) glitch(4'(1 << $urandom_range(0, 3)), $urandom_range(1, DB - 1));
        glitch(4'b1000, 10);

        chg_mode = 2;
        run_move(4'b0100, 2);
        check("unchanged_count", move_count, m_count);

        chg_mode = 0;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) glitch(4'($urandom_range(1, 15)), $urandom_range(1, DB - 1));
            run_move(4'($urandom_range(1, 15)), $urandom_range(0, 2 * DB));
        end

        chg_mode = 1;
        for (int i = 0; i < CMAX + 1; i++) run_move(4'($urandom_range(1, 15)), $urandom_range(0, 4));
        check("count_saturated", move_count, CMAX);

        // game over, then everything is ignored until reset
        dead_next = 1;
        run_move(4'b0010, 2);
        check("death_set", death, 1'b1);
        m_dead = 1;
        dead_next = 0;
        run_move(4'b0001, 2);
        run_move(4'b1111, 2);
        check("death_sticky", death, 1'b1);
        check("dead_not_busy", busy, 1'b0);
        #2 clr = 0;
        #1;
        check("clr_death", death, 1'b0);
        check("clr_count", move_count, 0);
        flush_model();
        cyc(2);
        clr = 1;
        cyc(DB + 3);
        m_armed = 1;

        // reset in the middle of a spawn handshake
        hold_ack = 1;
        set_btn(4'b0001);
        q_dir.push_back(2'd0);
        m_armed = 0;
        for (int t = 0; t < 3000 && !spawn_req; t++) @(negedge clk);
        check("spawn_seen", spawn_req, 1'b1);
        #2 clr = 0;
        #1;
        check("clr_spawn_drop", spawn_req, 1'b0);
        check("clr_busy", busy, 1'b0);
        flush_model();
        hold_ack = 0;
        cyc(2);
        clr = 1;
        set_btn(4'd0);
        cyc(DB + 5);
        check("idle_after_clr", busy, 1'b0);
        m_armed = 1;
        run_move(4'b0100, 3);
        check("count_after_clr", move_count, m_count);
        check("queue_drained", 32'(q_dir.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
